// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised on-chip SRAM.
// Programmable wait states per OKAY data phase and a two-cycle ERROR response.
module ahb_sram_subordinate #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR =
    LO_ADDR + (ADDR_WIDTH+1)'(MEM_WORDS) * (ADDR_WIDTH+1)'(4);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ahb_sram_subordinate: DATA_WIDTH must be 32");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("ahb_sram_subordinate: MEM_WORDS must be a power of two >= 2");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_sram_subordinate: WAIT_STATES must be 0..15");
  end
  if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr_width
    $error("ahb_sram_subordinate: ADDR_WIDTH too small for MEM_WORDS");
  end
  if (BASE_ADDR[IDX_W+1:0] != '0) begin : g_bad_base
    $error("ahb_sram_subordinate: BASE_ADDR must be aligned to MEM_WORDS*4");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              ofs_q, ofs_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic                    in_range, misalign, req_err, accept;
  logic [3:0]              be;

  logic unused_ok;
  assign unused_ok = ^HBURST;

  always_comb begin
    in_range = ({1'b0, HADDR} >= LO_ADDR) && ({1'b0, HADDR} < HI_ADDR);
    misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
               ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    req_err  = !in_range || (HSIZE > 3'd2) || misalign;
    // Only states that present HREADYOUT=1 can end a data phase and take a new address.
    accept   = HSEL && HREADY && HTRANS[1] &&
               ((state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ofs_d   = ofs_q;
    write_d = write_q;
    size_d  = size_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      idx_d   = HADDR[IDX_W+1:2];
      ofs_d   = HADDR[1:0];
      write_d = HWRITE;
      size_d  = HSIZE;
      if (req_err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = S_LAST;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ofs_q   <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ofs_q   <= ofs_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    case (size_q)
      3'd0:    be = 4'b0001 << ofs_q;
      3'd1:    be = ofs_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory has no reset; a reset abandons LAST before this edge, so no commit happens.
  always_ff @(posedge HCLK) begin
    if ((state_q == S_LAST) && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    HRDATA    = ((state_q == S_LAST) && !write_q) ? mem[idx_q] : '0;
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: two instances (0 and 3 wait states) checked
// against a byte-addressed reference model with directed tables and random traffic.
module tb_ahb_sram_subordinate;

  localparam int unsigned MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  hsel, hwrite, hready, hreadyout, hresp, stall;
  logic [31:0] haddr [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize [2];
  logic [2:0]  hburst [2];

  logic [31:0] mdl [2][MW];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign hready[0] = hreadyout[0] & ~stall[0];
  assign hready[1] = hreadyout[1] & ~stall[1];

  ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW),
                         .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW),
                         .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a transfer covers bytes [a, a+2**sz) and must lie in the window, naturally aligned.
  function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
    longint unsigned aa = a;
    if (aa < BASE || aa >= longint'(BASE) + MW * 4) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    if ((aa % (1 << sz)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int unsigned w = (a - BASE) / 4;
    int unsigned nb = 1 << sz;
    for (int b = 0; b < 4; b++) begin
      int unsigned ba = BASE + w * 4 + b;
      if (ba >= a && ba < a + nb) mdl[d][w][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic idle_bus(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'd0; hwrite[d] = 1'b0;
    hsize[d] = 3'd2; haddr[d] = '0;
  endtask

  // Single non-pipelined transfer; entered and left #1 after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input string tag,
                      output logic [31:0] rd_o, output logic resp_o);
    bit err = model_err(a, sz);
    logic [31:0] exp_rd = (!wr && !err) ? mdl[d][(a - BASE) >> 2] : 32'h0;
    int lows = 0;
    bit done = 1'b0;
    bit lowbad = 1'b0;
    hsel[d] = 1'b1; htrans[d] = 2'd2; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    hburst[d] = 3'($urandom);
    @(posedge clk); #1;
    idle_bus(d);
    hwdata[d] = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hreadyout[d] === 1'b1) begin done = 1'b1; break; end
      lows++;
      if (hresp[d] !== err || hrdata[d] !== 32'h0) lowbad = 1'b1;
    end
    rd_o = hrdata[d];
    resp_o = hresp[d];
    check($sformatf("%s timeout", tag), 32'(done), 32'd1);
    check($sformatf("%s stall_cycles", tag), lows, err ? 1 : ws_of(d));
    check($sformatf("%s hresp", tag), 32'(resp_o), 32'(err));
    check($sformatf("%s stall_phase", tag), 32'(lowbad), 32'd0);
    if (!wr || err) check($sformatf("%s hrdata", tag), rd_o, exp_rd);
    @(posedge clk); #1;
    hwdata[d] = '0;
    if (wr && !err) model_write(d, a, sz, wd);
  endtask

  // Write then read of the same word with the read's address phase overlapping the write's data phase.
  task automatic b2b(input int d, input logic [31:0] a, input logic [31:0] wd);
    int lows;
    bit done;
    hsel[d] = 1'b1; htrans[d] = 2'd2; haddr[d] = a; hwrite[d] = 1'b1; hsize[d] = 3'd2;
    @(posedge clk); #1;
    hwrite[d] = 1'b0;
    hwdata[d] = wd;
    lows = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hreadyout[d] === 1'b1) begin done = 1'b1; break; end
      lows++;
    end
    check($sformatf("b2b%0d wr_done", d), 32'(done), 32'd1);
    check($sformatf("b2b%0d wr_stall", d), lows, ws_of(d));
    @(posedge clk); #1;
    idle_bus(d);
    hwdata[d] = '0;
    lows = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hreadyout[d] === 1'b1) begin done = 1'b1; break; end
      lows++;
    end
    check($sformatf("b2b%0d rd_done", d), 32'(done), 32'd1);
    check($sformatf("b2b%0d rd_stall", d), lows, ws_of(d));
    check($sformatf("b2b%0d rd_resp", d), 32'(hresp[d]), 32'd0);
    check($sformatf("b2b%0d rd_data", d), hrdata[d], wd);
    @(posedge clk); #1;
    model_write(d, a, 3'd2, wd);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] off;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] rd, old;
    logic        resp;

    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old;
    logic        resp;

    tbl[0] = '{1'b1, 32'h10,  3'd2, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h12,  3'd0, 32'h00A50000, 32'h0,        1'b0};
    tbl[3] = '{1'b1, 32'h10,  3'd1, 32'h00001234, 32'h0,        1'b0};
    tbl[4] = '{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEA51234, 1'b0};
    tbl[5] = '{1'b0, 32'h100, 3'd2, 32'h0,        32'h0,        1'b1};
    tbl[6] = '{1'b1, 32'h11,  3'd2, 32'h55555555, 32'h0,        1'b1};
    tbl[7] = '{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEA51234, 1'b0};
    tbl[8] = '{1'b1, 32'h13,  3'd1, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[9] = '{1'b0, 32'h10,  3'd3, 32'h0,        32'h0,        1'b1};

    stall = '0;
    for (int d = 0; d < 2; d++) begin
      idle_bus(d);
      hwdata[d] = '0;
      hburst[d] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d hreadyout", d), 32'(hreadyout[d]), 32'd1);
      check($sformatf("reset%0d hresp", d), 32'(hresp[d]), 32'd0);
      check($sformatf("reset%0d hrdata", d), hrdata[d], 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < int'(MW); w++)
        xfer(d, 1'b1, BASE + 32'(w * 4), 3'd2, $urandom, $sformatf("init%0d", d), rd, resp);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        xfer(d, tbl[i].wr, BASE + tbl[i].off, tbl[i].sz, tbl[i].wd,
             $sformatf("vec%0d_%0d", d, i), rd, resp);
        check($sformatf("vec%0d_%0d tbl_resp", d, i), 32'(resp), 32'(tbl[i].exp_err));
        if (!tbl[i].wr) check($sformatf("vec%0d_%0d tbl_rd", d, i), rd, tbl[i].exp_rd);
      end
    end

    b2b(0, BASE, 32'h11111111);
    b2b(1, BASE, 32'h11111111);

    stall[0] = 1'b1;
    hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = BASE + 32'h10; hwrite[0] = 1'b0; hsize[0] = 3'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall c%0d hreadyout", c), 32'(hreadyout[0]), 32'd1);
      check($sformatf("stall c%0d hrdata", c), hrdata[0], 32'h0);
    end
    @(posedge clk); #1;
    idle_bus(0);
    stall[0] = 1'b0;
    @(negedge clk);
    check("stall no_accept hrdata", hrdata[0], 32'h0);
    check("stall no_accept hresp", 32'(hresp[0]), 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] a;
        logic [2:0]  sz;
        bit          wr;
        if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 16));
        else                           a = BASE + 32'($urandom_range(0, MW * 4 + 15));
        sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        wr = 1'($urandom);
        xfer(d, wr, a, sz, $urandom, $sformatf("rnd%0d_%0d", d, n), rd, resp);
      end
    end

    old = mdl[1][8];
    hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = BASE + 32'h20; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    idle_bus(1);
    hwdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    check("rstmid in_wait", 32'(hreadyout[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid hreadyout", 32'(hreadyout[1]), 32'd1);
    check("rstmid hresp", 32'(hresp[1]), 32'd0);
    check("rstmid hrdata", hrdata[1], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hwdata[1] = '0;
    xfer(1, 1'b0, BASE + 32'h20, 3'd2, 32'h0, "rstmid readback", rd, resp);
    check("rstmid unchanged", rd, old);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

AHB-Lite subordinate backing a word-organised on-chip memory. It sits directly downstream of the Renode AHB manager in co-simulation testbenches: it consumes the manager's address/data-phase transfers and returns HRDATA, HREADYOUT and HRESP. Wait-state insertion and two-cycle ERROR responses are built in, so the manager's stall and error paths can be exercised against synthesizable RTL.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 only (other values rejected at elaboration)
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words; power of two
- BASE_ADDR, 0, byte address of word 0; aligned to MEM_WORDS*4
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; 0..15
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  reset; asynchronous, active-low
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 halfword, 2 word
- HBURST  in  3  accepted, not decoded
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-level ready (end of previous data phase)
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  DATA_WIDTH  read data

## Operation
- Address phase accepted at a rising edge where HSEL & HREADY & HTRANS[1]. The block captures addr, write, size, and an error flag into data-phase registers.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no data phase follows. The block responds zero-wait OKAY (HREADYOUT=1, HRESP=0).
- The error flag is set when any of these hold:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4)
  - HSIZE > 2
  - misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0. On accept with error → ERR1. On accept without error → WAIT if WAIT_STATES>0, else LAST.
  - WAIT: HREADYOUT=0, HRESP=0. A down-counter is loaded with WAIT_STATES-1; → LAST when the counter reaches 0.
  - LAST: HREADYOUT=1, HRESP=0. The transfer completes at this edge. A new accept here follows the same rules as IDLE. Otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. New accept follows the IDLE rules, else → IDLE.
- Write: at the completing edge (LAST), memory is updated with HWDATA on the byte lanes selected by size and addr[1:0]. Other lanes are unchanged.
- Read: during LAST, HRDATA = mem[data-phase word index], full word, all lanes. HRDATA is 0 in all other states.
- Errored transfers never modify memory. HRDATA is 0 throughout an error response.
- HBURST is ignored; each beat of a burst is handled as an independent transfer.
- Memory contents are not cleared by reset; initial contents are undefined (X in sim).

## Timing
- Reset (HRESETn low, asynchronous): state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0. Memory is untouched.
- Reset asserted mid-transfer abandons it: a pending write is not committed. The first edge after release may accept a new address phase.
- WAIT_STATES=N: address-phase edge T0, HREADYOUT low for T0+1..T0+N, completing edge T0+N+1. Read data is valid in the cycle before that edge.
- Error: HREADYOUT low exactly 1 cycle with HRESP=1, then 1 cycle HREADYOUT=1 with HRESP=1.
- Back-to-back pipelining: the address phase of transfer k+1 is accepted at the completing edge of transfer k.
- Write then read to the same word back-to-back returns the new data: the write commits at the same edge the read's address is captured.
- HREADY low while in IDLE (another subordinate stalling): no accept; outputs hold at their IDLE values.

## Test plan
- Reset, then word write 0xDEADBEEF to BASE_ADDR+0x10 and read it back with WAIT_STATES=0 → read returns 0xDEADBEEF, HREADYOUT never low, HRESP=0.
- WAIT_STATES=3, read of 0x10 → HREADYOUT low exactly 3 cycles, then 0xDEADBEEF with OKAY.
- Byte write 0xA5 at 0x12, then halfword write 0x1234 at 0x10, then word read at 0x10 → 0xDEA51234.
- Word read at BASE_ADDR+MEM_WORDS*4, and word write at 0x11 (misaligned) → each gets a two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1). The following read of 0x10 still returns its prior value.
- Back-to-back NONSEQ write 0x11111111 @0x0 followed immediately by read @0x0 → read returns 0x11111111 with no extra stall.
- Assert HRESETn low during a WAIT-state write of 0xCAFEF00D to 0x20 → HREADYOUT=1, HRESP=0, HRDATA=0 immediately. Word 0x20 is not updated.
